// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions N raw, active-high, asynchronous pushbuttons into clean control
// strobes for the game top level. Each button gets its own pipeline:
//   2-flop synchroniser -> counter debouncer -> registered level stage
//   -> press/release edge strobes -> optional auto-repeat engine.
//
// Bit order of every N-wide bus:
//   [0] clockwise, [1] anti_clkwise, [2] down, [3] left, [4] right, [5] select
//
// Parameters:
//   N            number of buttons
//   DB_CYCLES    cycles the synchronised input must hold a new value before
//                the debounced level follows it (>= 1)
//   REPEAT_DELAY cycles from a press strobe to the first auto-repeat (>= 2)
//   REPEAT_RATE  cycles between later auto-repeat strobes (>= 2)
//   REPEAT_MASK  per-button auto-repeat enable
//
// Ports:
//   clk          system clock
//   resetn       asynchronous active-low reset; clears all state
//   btn_raw      raw button inputs, asynchronous to clk
//   btn_level    debounced, registered button level
//   btn_press    one-cycle strobe per debounced press and per auto-repeat
//   btn_release  one-cycle strobe per debounced release
//
// Build option:
//   BTN_REPEAT_ACCEL_EN  when defined, a held repeating button switches to
//                        period REPEAT_RATE/2 (minimum 2) after 8 repeats.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int unsigned  N            = 6,
  parameter int unsigned  DB_CYCLES    = 1000000,
  parameter int unsigned  REPEAT_DELAY = 25000000,
  parameter int unsigned  REPEAT_RATE  = 5000000,
  parameter logic [N-1:0] REPEAT_MASK  = 6'b011100
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release
);

  localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

`ifdef BTN_REPEAT_ACCEL_EN
  localparam int unsigned      FAST_RATE  = ((REPEAT_RATE / 2) < 2) ? 2 : (REPEAT_RATE / 2);
  localparam logic [RPT_W-1:0] FAST_LAST  = RPT_W'(FAST_RATE - 1);
`endif

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;

  for (genvar i = 0; i < N; i++) begin : g_btn
    logic             sync1_q, sync2_q;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             stable_q, stable_d;
    logic             level_q, press_q, release_q;
    logic             rise, fall;
    rpt_state_e       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [RPT_W-1:0] period_last;
    logic             rpt_fire;
`ifdef BTN_REPEAT_ACCEL_EN
    logic [2:0]       acc_q, acc_d;
`endif

    // Debounce: count consecutive cycles of disagreement between the
    // synchronised input and the accepted level; any agreement restarts it.
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
      db_cnt_d = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
        if (db_cnt_q == DB_LAST) begin
          stable_d = sync2_q;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
    end

    // Edges of the accepted level, seen one cycle before the registered
    // level moves, so the strobes line up with btn_level.
    assign rise = stable_q & ~level_q;
    assign fall = ~stable_q & level_q;

`ifdef BTN_REPEAT_ACCEL_EN
    // acc_q counts strobes issued from REPEAT (the DELAY strobe is not
    // counted), so saturation at 7 means 8 repeats have gone out in total.
    assign period_last = (acc_q == 3'd7) ? FAST_LAST : RATE_LAST;
`else
    assign period_last = RATE_LAST;
`endif

    // Auto-repeat engine. A debounced fall always wins over a counter
    // expiry in the same cycle, so no repeat lands on a release.
    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      rpt_fire  = 1'b0;
`ifdef BTN_REPEAT_ACCEL_EN
      acc_d     = acc_q;
`endif
      case (state_q)
        RPT_IDLE: begin
          rpt_cnt_d = '0;
`ifdef BTN_REPEAT_ACCEL_EN
          acc_d     = '0;
`endif
          if (rise && REPEAT_MASK[i]) begin
            state_d = RPT_DELAY;
          end
        end
        RPT_DELAY: begin
          if (fall) begin
            state_d   = RPT_IDLE;
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == DELAY_LAST) begin
            rpt_fire  = 1'b1;
            rpt_cnt_d = '0;
            state_d   = RPT_REPEAT;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (fall) begin
            state_d   = RPT_IDLE;
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == period_last) begin
            rpt_fire  = 1'b1;
            rpt_cnt_d = '0;
`ifdef BTN_REPEAT_ACCEL_EN
            if (acc_q != 3'd7) begin
              acc_d = acc_q + 3'd1;
            end
`endif
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
          end
        end
        default: begin
          state_d   = RPT_IDLE;
          rpt_cnt_d = '0;
        end
      endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, which the synchroniser chain relies on.
    // All state, counters included, is cleared by reset so a held button
    // re-debounces from zero afterwards.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        db_cnt_q  <= '0;
        stable_q  <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        state_q   <= RPT_IDLE;
        rpt_cnt_q <= '0;
`ifdef BTN_REPEAT_ACCEL_EN
        acc_q     <= '0;
`endif
      end else begin
        sync1_q   <= btn_raw[i];
        sync2_q   <= sync1_q;
        db_cnt_q  <= db_cnt_d;
        stable_q  <= stable_d;
        level_q   <= stable_q;
        press_q   <= rise | rpt_fire;
        release_q <= fall;
        state_q   <= state_d;
        rpt_cnt_q <= rpt_cnt_d;
`ifdef BTN_REPEAT_ACCEL_EN
        acc_q     <= acc_d;
`endif
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule
